fifo_ctrl: RTL

//  Control and output stage of the 8-entry, 32-bit FIFO. Holds head/tail pointers and occupancy count,

---
 rtl/fifo_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// Control and output stage of an 8-entry FIFO built around an external register file.
// Tracks head/tail/occupancy, drives the register-file ports, and reports per-operation status.
module fifo_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_raddr,
    output logic [DATA_W-1:0] d_out,
    output logic [ADDR_W:0]   data_count,
    output logic              full,
    output logic              empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err
);

    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WR_ERROR,
        READ,
        RD_ERROR
    } op_t;

    op_t               state;
    op_t               next_state;
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [ADDR_W:0]   count;

    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);
    assign data_count = count;
    assign rf_waddr   = head;
    assign rf_raddr   = tail;

    // Simultaneous read and write is treated as no operation; reset suppresses every request.
    always_comb begin
        next_state = IDLE;
        if (!reset) begin
            if (wr_en && !rd_en) begin
                next_state = full ? WR_ERROR : WRITE;
            end else if (rd_en && !wr_en) begin
                next_state = empty ? RD_ERROR : READ;
            end
        end
    end

    assign rf_we = (next_state == WRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            d_out <= '0;
        end else begin
            case (next_state)
                WRITE: begin
                    head  <= head + PTR_ONE;
                    count <= count + CNT_ONE;
                end
                READ: begin
                    d_out <= rf_rdata;
                    tail  <= tail + PTR_ONE;
                    count <= count - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Status flags are Moore outputs of the registered operation.
    always_comb begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        rd_ack = 1'b0;
        rd_err = 1'b0;
        case (state)
            WRITE:    wr_ack = 1'b1;
            WR_ERROR: wr_err = 1'b1;
            READ:     rd_ack = 1'b1;
            RD_ERROR: rd_err = 1'b1;
            default:  ;
        endcase
    end

endmodule
